run_scan_ctrl: RTL

//  Sequencer for the serial run-of-ones detector datapath.
//  - Accepts a parallel word on a start pulse and shifts it out MSB-first, one bit per clock.
//  - Runs an internal Mealy run-length detector on the serialised bits.
//  - Counts detections and reports the total with a one-cycle done pulse.
//  - Sits between a register/command interface and the serial detection path.

---
 rtl/run_scan_ctrl.sv | 106 ++++++++++
 1 files changed

// File: rtl/run_scan_ctrl.sv
// Serial run-of-ones scan sequencer: loads a word on start, shifts it out MSB-first,
// flags runs of RUN_LEN ones with a Mealy detector and reports a saturating match count.
module run_scan_ctrl #(
    parameter int WIDTH   = 8,
    parameter int RUN_LEN = 4,
    parameter int CNT_W   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_overlap,
    output logic             o_busy,
    output logic             o_bit_out,
    output logic             o_bit_valid,
    output logic             o_match,
    output logic [CNT_W-1:0] o_match_count,
    output logic             o_done
);

    localparam int RUN_W = $clog2(RUN_LEN);
    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(RUN_LEN - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_accept;
    logic [WIDTH-1:0]   r_shreg;
    logic [RUN_W-1:0]   r_run;
    logic [IDX_W-1:0]   r_idx;
    logic [CNT_W-1:0]   r_count;
    logic               r_overlap;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        o_busy      = 1'b0;
        o_bit_valid = 1'b0;
        o_bit_out   = 1'b0;
        o_match     = 1'b0;
        o_done      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                o_busy      = 1'b1;
                o_bit_valid = 1'b1;
                o_bit_out   = r_shreg[WIDTH-1];
                o_match     = r_shreg[WIDTH-1] && (r_run == RUN_MAX);
                if (r_idx == IDX_LAST) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                o_busy      = 1'b1;
                o_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shreg   <= '0;
            r_run     <= '0;
            r_idx     <= '0;
            r_count   <= '0;
            r_overlap <= 1'b0;
        end else if (w_accept) begin
            r_shreg   <= i_din;
            r_overlap <= i_overlap;
            r_run     <= '0;
            r_idx     <= '0;
            r_count   <= '0;
        end else if (r_state == S_SHIFT) begin
            r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
            r_idx   <= r_idx + 1'b1;
            // Overlapping mode parks the run at its ceiling so each further 1 matches again.
            if (!o_bit_out)    r_run <= '0;
            else if (o_match)  r_run <= r_overlap ? RUN_MAX : '0;
            else               r_run <= r_run + 1'b1;
            if (o_match && (r_count != CNT_MAX)) r_count <= r_count + 1'b1;
        end
    end

    assign o_match_count = r_count;

endmodule
